vproc_div_seq: RTL and testbench
================================

VPROC_DIV_SEQ -- requirements
Module: vproc_div_seq

Interface
REQ-001 SHALL have parameter ELEM_CNT, default 4, number of 32-bit elements per operation (1..16).
REQ-002 SHALL have parameter DIV_LAT, default 3, register stages in the downstream divider (0..3).
REQ-003 SHALL have port clk_i  input  1  clock; the block uses one clock only.
REQ-004 SHALL have port sync_rst_ni  input  1  reset; reset is synchronous and active-low.
REQ-005 SHALL have port op_valid_i  input  1  operation request.
REQ-006 SHALL have port op_ready_o  output  1  operation accept.
REQ-007 SHALL have port op_mod_i  input  1  0 = quotient, 1 = remainder.
REQ-008 SHALL have ports op1_i, op2_i, vd_i  input  ELEM_CNT*32  dividend, divisor and old destination; element k is at bits [32k+31:32k].
REQ-009 SHALL have port mask_i  input  ELEM_CNT  per-element enable.
REQ-010 SHALL have ports div_mod_o  output  1, and div_op1_o, div_op2_o  output  32; these drive the divider.
REQ-011 SHALL have port div_res_i  input  32  divider result.
REQ-012 SHALL have ports res_valid_o  output  1, res_ready_i  input  1, res_o  output  ELEM_CNT*32  result.

Function
REQ-013 SHALL use an FSM with states IDLE, ISSUE, DRAIN and DONE.
REQ-014 SHALL drive op_ready_o high only in IDLE.
REQ-015 SHALL, on an op_valid_i && op_ready_o edge, register op1_i, op2_i, vd_i, mask_i and op_mod_i, clear the issue counter, and enter ISSUE.
REQ-016 SHALL, in ISSUE, drive element idx of the registered operands onto div_op1_o and div_op2_o, and increment idx each cycle.
- After idx = ELEM_CNT-1, go to DRAIN, or to DONE when DIV_LAT = 0.
REQ-017 SHALL hold div_mod_o at the registered mod for the whole operation.
REQ-018 SHALL drive div_op1_o and div_op2_o to 0 outside ISSUE.
REQ-019 SHALL carry a valid bit and element index per issued element through a DIV_LAT-deep tag delay line.
- When a tag emerges valid, div_res_i SHALL be written to result element idx.
- When DIV_LAT = 0, the write SHALL happen in the issue cycle.
REQ-020 SHALL, in DRAIN, move to DONE in the cycle the last tag (idx = ELEM_CNT-1) is written.
REQ-021 SHALL, for elements with mask bit 0, write the vd_i element instead of div_res_i; these elements are still issued, so latency is fixed.
REQ-022 SHALL assert res_valid_o only in DONE.
- If the accepting edge is t, res_valid_o SHALL rise at t+ELEM_CNT+DIV_LAT.
REQ-023 SHALL hold res_o and res_valid_o stable while res_ready_i is low.
- On the res_valid_o && res_ready_i edge, the FSM SHALL return to IDLE.
- The next operation can be accepted no earlier than the following edge.
REQ-024 SHALL ignore op_valid_i outside IDLE.
- Operand input changes outside IDLE SHALL have no effect.
REQ-025 SHALL handle ELEM_CNT = 1 and DIV_LAT = 0 without dead cycles beyond REQ-022.

Reset
REQ-026 SHALL, while sync_rst_ni is low at a clock edge, set the FSM to IDLE and clear the issue counter and all tag valid bits.
REQ-027 SHALL drive these values in the cycle after reset: op_ready_o = 1, res_valid_o = 0, div_op1_o = 0, div_op2_o = 0, div_mod_o = 0, res_o = 0.
REQ-028 SHALL, when reset occurs mid-operation, discard the operation; results still in flight in the divider SHALL NOT be written to res_o.

Structure
REQ-029 SHALL define the FSM state enum div_seq_state_e in vproc_pkg.
REQ-030 SHALL implement the tag delay line as sub-module vproc_div_tag_pipe, parameterised by DEPTH and index width, with a pass-through when DEPTH = 0.
REQ-031 SHALL NOT instantiate the divider; the parent connects div_* to it with DIV_LAT = BUF_OPS+BUF_DIV+BUF_RES.

Verification
REQ-032 SHALL cover signed quotient: ELEM_CNT=4, DIV_LAT=3, mod=0, mask=4'b1111, op1={20,-7,7,0x80000000}, op2={3,2,0,-1}.
- Required: res_o={6,-3,0xFFFFFFFF,0x80000000}, with res_valid_o at t+7.
REQ-033 SHALL cover remainder: same operands as REQ-032 with mod=1.
- Required: res_o={2,-1,7,0}.
REQ-034 SHALL cover masking: mask=4'b0101, vd_i all 0xDEADBEEF.
- Required: elements 1 and 3 = 0xDEADBEEF; elements 0 and 2 are the divide results.
REQ-035 SHALL cover backpressure: res_ready_i low for 5 cycles with op_valid_i high.
- Required: res_o stable, op_ready_o low, and no second operation accepted.
REQ-036 SHALL cover mid-operation reset: sync_rst_ni low for 1 cycle at issue idx = 2.
- Required: op_ready_o = 1 and res_valid_o = 0 on the next cycle.
- A following op with op1=9, op2=4 SHALL return exactly {2,...}, with no stale writes.
REQ-037 SHALL cover the minimum configuration: ELEM_CNT=1, DIV_LAT=0, op1=100, op2=7, mod=1.
- Required: res_o=2, with res_valid_o at t+1.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared types and helpers for the vector divide sequencer and its tag pipeline.
package vproc_pkg;

  localparam int unsigned ELEM_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } div_seq_state_e;

  // Width of an element index; a single-element vector still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vproc_div_tag_pipe.sv
// Delay line that tracks which element index each divider pipeline slot holds.
module vproc_div_tag_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             sync_rst_ni,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk_i ^ sync_rst_ni;
    assign valid_o       = valid_i;
    assign idx_o         = idx_i;
  end else begin : g_pipe
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

    always_comb begin
      valid_d    = valid_q;
      idx_d      = idx_q;
      valid_d[0] = valid_i;
      idx_d[0]   = idx_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        idx_d[i]   = idx_q[i-1];
      end
    end

    // Only the valid bits need clearing; a stale index is never consumed.
    always_ff @(posedge clk_i) begin
      if (!sync_rst_ni) begin
        valid_q <= '0;
      end else begin
        valid_q <= valid_d;
      end
      idx_q <= idx_d;
    end

    assign valid_o = valid_q[DEPTH-1];
    assign idx_o   = idx_q[DEPTH-1];
  end

endmodule

// File: rtl/vproc_div_seq.sv
// Feeds ELEM_CNT 32-bit elements through an external pipelined divider one per
// cycle and gathers the results (or the old destination for masked elements).
module vproc_div_seq
  import vproc_pkg::*;
#(
  parameter int unsigned ELEM_CNT = 4,
  parameter int unsigned DIV_LAT  = 3
) (
  input  logic                         clk_i,
  input  logic                         sync_rst_ni,
  input  logic                         op_valid_i,
  output logic                         op_ready_o,
  input  logic                         op_mod_i,
  input  logic [ELEM_CNT*ELEM_W-1:0]   op1_i,
  input  logic [ELEM_CNT*ELEM_W-1:0]   op2_i,
  input  logic [ELEM_CNT*ELEM_W-1:0]   vd_i,
  input  logic [ELEM_CNT-1:0]          mask_i,
  output logic                         div_mod_o,
  output logic [ELEM_W-1:0]            div_op1_o,
  output logic [ELEM_W-1:0]            div_op2_o,
  input  logic [ELEM_W-1:0]            div_res_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [ELEM_CNT*ELEM_W-1:0]   res_o
);

  localparam int unsigned      IDX_W    = idx_width(ELEM_CNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEM_CNT - 1);

  div_seq_state_e                  state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [ELEM_CNT-1:0][ELEM_W-1:0] op1_q, op1_d;
  logic [ELEM_CNT-1:0][ELEM_W-1:0] op2_q, op2_d;
  logic [ELEM_CNT-1:0][ELEM_W-1:0] vd_q, vd_d;
  logic [ELEM_CNT-1:0][ELEM_W-1:0] res_q, res_d;
  logic [ELEM_CNT-1:0]             mask_q, mask_d;
  logic                            mod_q, mod_d;
  logic                            op_ready_q, op_ready_d;
  logic                            res_valid_q, res_valid_d;

  logic             issue;
  logic             tag_valid;
  logic [IDX_W-1:0] tag_idx;

  assign issue = (state_q == ISSUE);

  vproc_div_tag_pipe #(
    .DEPTH (DIV_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk_i       (clk_i),
    .sync_rst_ni (sync_rst_ni),
    .valid_i     (issue),
    .idx_i       (idx_q),
    .valid_o     (tag_valid),
    .idx_o       (tag_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    vd_d    = vd_q;
    mask_d  = mask_q;
    mod_d   = mod_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (op_valid_i && op_ready_q) begin
          op1_d   = op1_i;
          op2_d   = op2_i;
          vd_d    = vd_i;
          mask_d  = mask_i;
          mod_d   = op_mod_i;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = (DIV_LAT == 0) ? DONE : DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (tag_valid && (tag_idx == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Masked elements still occupy a divider slot; only the write source differs.
    if (tag_valid) begin
      res_d[tag_idx] = mask_q[tag_idx] ? div_res_i : vd_q[tag_idx];
    end

    op_ready_d  = (state_d == IDLE);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      vd_q        <= '0;
      mask_q      <= '0;
      mod_q       <= 1'b0;
      res_q       <= '0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      vd_q        <= vd_d;
      mask_q      <= mask_d;
      mod_q       <= mod_d;
      res_q       <= res_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign op_ready_o  = op_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign div_mod_o   = mod_q;
  assign div_op1_o   = issue ? op1_q[idx_q] : '0;
  assign div_op2_o   = issue ? op2_q[idx_q] : '0;

endmodule

// File: tb/tb_vproc_div_seq.sv
// Directed bench for vproc_div_seq: a 4-element/3-stage instance and a
// 1-element/combinational-divider instance, each driving a reference divider.
module tb_vproc_div_seq;

  localparam logic [127:0] Q_OP1 = {32'd20, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
  localparam logic [127:0] Q_OP2 = {32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF};
  localparam logic [127:0] Q_RES = {32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
  localparam logic [127:0] R_RES = {32'd2, 32'hFFFF_FFFF, 32'd7, 32'd0};
  localparam logic [127:0] VD_BEEF = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] M_RES = {32'hDEAD_BEEF, 32'hFFFF_FFFD, 32'hDEAD_BEEF, 32'h8000_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  logic         op_valid = 1'b0, op_ready, op_mod = 1'b0;
  logic [127:0] op1 = '0, op2 = '0, vd = '0, res;
  logic [3:0]   op_mask = '0;
  logic         div_mod, res_valid, res_ready = 1'b0;
  logic [31:0]  div_op1, div_op2, div_res;
  logic [31:0]  dq0, dq1, dq2;

  logic        m_op_valid = 1'b0, m_op_ready, m_mod = 1'b0;
  logic [31:0] m_op1 = '0, m_op2 = '0, m_vd = '0, m_res;
  logic [0:0]  m_mask = '0;
  logic        m_div_mod, m_res_valid, m_res_ready = 1'b0;
  logic [31:0] m_div_op1, m_div_op2, m_div_res;

  vproc_div_seq #(.ELEM_CNT(4), .DIV_LAT(3)) u_dut (
    .clk_i(clk), .sync_rst_ni(rst_n),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_mod_i(op_mod),
    .op1_i(op1), .op2_i(op2), .vd_i(vd), .mask_i(op_mask),
    .div_mod_o(div_mod), .div_op1_o(div_op1), .div_op2_o(div_op2), .div_res_i(div_res),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res)
  );

  vproc_div_seq #(.ELEM_CNT(1), .DIV_LAT(0)) u_min (
    .clk_i(clk), .sync_rst_ni(rst_n),
    .op_valid_i(m_op_valid), .op_ready_o(m_op_ready), .op_mod_i(m_mod),
    .op1_i(m_op1), .op2_i(m_op2), .vd_i(m_vd), .mask_i(m_mask),
    .div_mod_o(m_div_mod), .div_op1_o(m_div_op1), .div_op2_o(m_div_op2), .div_res_i(m_div_res),
    .res_valid_o(m_res_valid), .res_ready_i(m_res_ready), .res_o(m_res)
  );

  // Signed divide with the usual vector-ISA corner cases.
  function automatic logic [31:0] ref_div(input logic m, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return m ? a : 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'd0 : 32'h8000_0000;
    return m ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  always @(posedge clk) begin
    dq0 <= ref_div(div_mod, div_op1, div_op2);
    dq1 <= dq0;
    dq2 <= dq1;
  end
  assign div_res = dq2;
  always_comb m_div_res = ref_div(m_div_mod, m_div_op1, m_div_op2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic m, input logic [3:0] mk, input logic [127:0] a,
                          input logic [127:0] b, input logic [127:0] v);
    op_valid = 1'b1; op_mod = m; op_mask = mk; op1 = a; op2 = b; vd = v;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_ready_back"}, 128'(op_ready), 128'(1'b1));
    check({tag, "_valid_drop"}, 128'(res_valid), 128'(1'b0));
  endtask

  initial begin
    int lat;
    logic [127:0] held;

    tick();
    tick();
    rst_n = 1'b1;
    check("rst_op_ready", 128'(op_ready), 128'(1'b1));
    check("rst_res_valid", 128'(res_valid), 128'(1'b0));
    check("rst_div_op1", 128'(div_op1), 128'(0));
    check("rst_div_op2", 128'(div_op2), 128'(0));
    check("rst_div_mod", 128'(div_mod), 128'(1'b0));
    check("rst_res", res, 128'(0));
    check("rst_min_ready", 128'(m_op_ready), 128'(1'b1));
    check("rst_min_res", 128'(m_res), 128'(0));

    // Signed quotient
    start_op(1'b0, 4'b1111, Q_OP1, Q_OP2, '0);
    check("q_ready_low", 128'(op_ready), 128'(1'b0));
    check("q_issue0_op1", 128'(div_op1), 128'(32'h8000_0000));
    check("q_issue0_op2", 128'(div_op2), 128'(32'hFFFF_FFFF));
    tick();
    check("q_issue1_op1", 128'(div_op1), 128'(32'd7));
    check("q_issue1_op2", 128'(div_op2), 128'(32'd0));
    tick(); tick(); tick();
    check("q_drain_op1", 128'(div_op1), 128'(0));
    check("q_drain_op2", 128'(div_op2), 128'(0));
    check("q_drain_valid", 128'(res_valid), 128'(1'b0));
    wait_valid(4, lat);
    check("q_latency", 128'(lat), 128'(7));
    check("q_res", res, Q_RES);
    finish_op("q");

    // Remainder
    start_op(1'b1, 4'b1111, Q_OP1, Q_OP2, '0);
    check("r_div_mod", 128'(div_mod), 128'(1'b1));
    wait_valid(0, lat);
    check("r_latency", 128'(lat), 128'(7));
    check("r_res", res, R_RES);
    finish_op("r");

    // Masking
    start_op(1'b0, 4'b0101, Q_OP1, Q_OP2, VD_BEEF);
    wait_valid(0, lat);
    check("m_latency", 128'(lat), 128'(7));
    check("m_res", res, M_RES);
    finish_op("m");

    // Backpressure with a competing request held high
    start_op(1'b0, 4'b1111, Q_OP1, Q_OP2, '0);
    wait_valid(0, lat);
    check("bp_latency", 128'(lat), 128'(7));
    held = res;
    check("bp_res", held, Q_RES);
    op_valid = 1'b1; op_mod = 1'b1; op1 = '1; op2 = {4{32'd5}}; vd = '1; op_mask = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_res_stable", res, held);
      check("bp_ready_low", 128'(op_ready), 128'(1'b0));
      check("bp_valid_high", 128'(res_valid), 128'(1'b1));
    end
    op_valid = 1'b0;
    finish_op("bp");
    repeat (8) tick();
    check("bp_no_second_op", 128'(res_valid), 128'(1'b0));
    check("bp_still_idle", 128'(op_ready), 128'(1'b1));
    check("bp_idle_op1", 128'(div_op1), 128'(0));

    // Reset in the middle of issue
    start_op(1'b0, 4'b1111, Q_OP1, Q_OP2, '0);
    tick(); tick();
    check("mr_issue2_op1", 128'(div_op1), 128'(32'hFFFF_FFF9));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_op_ready", 128'(op_ready), 128'(1'b1));
    check("mr_res_valid", 128'(res_valid), 128'(1'b0));
    check("mr_res_cleared", res, 128'(0));
    repeat (4) tick();
    check("mr_no_stale_write", res, 128'(0));
    start_op(1'b0, 4'b1111, {4{32'd9}}, {4{32'd4}}, '0);
    wait_valid(0, lat);
    check("mr_latency", 128'(lat), 128'(7));
    check("mr_res", res, {4{32'd2}});
    finish_op("mr");

    // Minimum configuration
    m_op_valid = 1'b1; m_mod = 1'b1; m_mask = 1'b1; m_op1 = 32'd100; m_op2 = 32'd7; m_vd = 32'd0;
    tick();
    m_op_valid = 1'b0;
    check("min_issue_op1", 128'(m_div_op1), 128'(32'd100));
    check("min_issue_mod", 128'(m_div_mod), 128'(1'b1));
    check("min_t0_valid", 128'(m_res_valid), 128'(1'b0));
    tick();
    check("min_t1_valid", 128'(m_res_valid), 128'(1'b1));
    check("min_res", 128'(m_res), 128'(32'd2));
    check("min_busy", 128'(m_op_ready), 128'(1'b0));
    check("min_idle_op1", 128'(m_div_op1), 128'(0));
    m_res_ready = 1'b1;
    tick();
    m_res_ready = 1'b0;
    check("min_ready_back", 128'(m_op_ready), 128'(1'b1));
    check("min_valid_drop", 128'(m_res_valid), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
